firebird7_in_gate1_tessent_data_mux_sync: RTL and testbench
===========================================================

Name: firebird7_in_gate1_tessent_data_mux_sync

Overview:
- Multi-channel, parametrised successor of the IJTAG/functional data mux.
- Each channel independently switches its output between functional data and IJTAG data under its own select bit.
- Switch-over is registered and break-before-make: the output holds its last value for a programmable settle window before the new source is driven, so no glitch or partial word reaches downstream logic.
- Sits between the IJTAG network data registers and functional control inputs inside the gate1 instrument.

Parameters:
- WIDTH, 3, data bits per channel (>=1).
- NUM_CH, 1, number of independent channels (>=1).
- SETTLE_CYCLES, 2, hold cycles inserted on every source change (0 allowed).

Ports:
- ijtag_tck  input  1  the only clock; all state on rising edge.
- ijtag_reset  input  1  asynchronous, active-low reset.
- ijtag_select  input  NUM_CH  per-channel request; 1 = IJTAG source, 0 = functional.
- functional_data_in  input  NUM_CH*WIDTH  channel c in bits [c*WIDTH +: WIDTH].
- ijtag_data_in  input  NUM_CH*WIDTH  same packing.
- data_out  output  NUM_CH*WIDTH  registered muxed data, same packing.
- ijtag_active  output  NUM_CH  1 while channel c drives IJTAG data.
- switching  output  NUM_CH  1 while channel c is in a hold state.
- ijtag_capture_en  input  1  only when the macro is defined.
- capture_data  output  NUM_CH*WIDTH  only when the macro is defined.

Behaviour:
- Reset (ijtag_reset=0, async):
  - Every channel goes to FUNC.
  - data_out=0, ijtag_active=0, switching=0, counters=0, capture_data=0.
- Per-channel FSM states: FUNC, TO_IJTAG, IJTAG, TO_FUNC.
- FUNC:
  - data_out[c] <= functional_data_in[c] each cycle (1-cycle latency).
  - select=1 and SETTLE_CYCLES>0: go to TO_IJTAG, counter <= SETTLE_CYCLES-1.
  - select=1 and SETTLE_CYCLES==0: go to IJTAG directly; data_out takes ijtag_data_in that same edge.
- TO_IJTAG:
  - data_out holds; switching=1.
  - select returns to 0: go to FUNC next edge; data_out resumes functional on that edge.
  - Otherwise at counter==0: go to IJTAG and load ijtag_data_in on that edge. Else decrement the counter.
- IJTAG:
  - data_out[c] <= ijtag_data_in[c]; ijtag_active=1.
  - select=0 mirrors the FUNC rules, via TO_FUNC.
- TO_FUNC: symmetric to TO_IJTAG. Abort on select=1 returns to IJTAG.
- Timing:
  - ijtag_active is a registered state decode; it asserts on the edge the first IJTAG word is loaded and deasserts on the edge entering TO_FUNC.
  - Total switch latency, select edge to new-source data visible: SETTLE_CYCLES+1 cycles.
- Channels are fully independent; simultaneous requests on several channels proceed in parallel.
- Counter width: $clog2(SETTLE_CYCLES+1), minimum 1.
- Reset asserted mid-switch aborts to FUNC immediately with data_out=0.
- Select is assumed synchronous to ijtag_tck; no synchroniser is included.

Optional Feature:
- Macro: FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CAPTURE_EN.
- Defined:
  - Adds ijtag_capture_en and capture_data.
  - On an edge with ijtag_capture_en=1, capture_data <= data_out as registered before that edge, i.e. the value currently driven.
  - capture_data otherwise holds; reset value 0.
  - Lets the IJTAG network read back the driven value.
- Undefined: both ports and the capture register are absent; all other behaviour is identical.

Decomposition:
- Package firebird7_in_gate1_tessent_data_mux_pkg holds:
  - typedef enum logic [1:0] mux_state_e {FUNC, TO_IJTAG, IJTAG, TO_FUNC};
  - function cnt_width(settle), returning max(1, $clog2(settle+1)).
- Sub-module firebird7_in_gate1_tessent_data_mux_ch: one channel's FSM, counter and data register (params WIDTH, SETTLE_CYCLES).
  - Instantiated NUM_CH times in a generate loop.
  - The top level holds only packing and the optional capture register.

Test Plan:
- Reset, then run with select=0, fin=3'b101 (WIDTH=3, NUM_CH=1, SETTLE=2) -> data_out=0 during reset; data_out=3'b101 one cycle after release; ijtag_active=0.
- select 0->1 at cycle t, ijtag_data_in=3'b010 -> switching=1 on t+1..t+2 with data_out=3'b101 held; at t+3 data_out=3'b010, ijtag_active=1, switching=0.
- select pulses 1 for one cycle during FUNC -> TO_IJTAG for 1 cycle, back to FUNC; data_out never shows the IJTAG value; ijtag_active stays 0.
- SETTLE_CYCLES=0, NUM_CH=4, select=4'b0101 -> channels 0 and 2 show ijtag data the next cycle; channels 1 and 3 keep functional data; switching stays 0.
- Reset asserted in TO_IJTAG (counter=1) -> data_out=0, state FUNC immediately, no IJTAG word emitted after release.
- With the macro: drive data_out=3'b110, pulse ijtag_capture_en -> capture_data=3'b110 the next cycle, unchanged after a later data_out change.

Source files
------------

// File: rtl/firebird7_in_gate1_tessent_data_mux_pkg.sv
// firebird7_in_gate1_tessent_data_mux_pkg: shared state encoding and counter sizing for the gate1 data mux.
package firebird7_in_gate1_tessent_data_mux_pkg;

    typedef enum logic [1:0] {FUNC, TO_IJTAG, IJTAG, TO_FUNC} mux_state_e;

    function automatic int cnt_width(input int settle);
        return ($clog2(settle + 1) < 1) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_data_mux_ch.sv
// firebird7_in_gate1_tessent_data_mux_ch: one channel of the break-before-make functional/IJTAG data mux.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   sel       : 1 requests IJTAG source, 0 functional source
//   fin, ijd  : functional and IJTAG data words
//   data_out  : registered muxed word, held constant while settling
//   active    : channel is driving IJTAG data
//   switching : channel is in a settle (hold) state
module firebird7_in_gate1_tessent_data_mux_ch
    import firebird7_in_gate1_tessent_data_mux_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] fin,
    input  logic [WIDTH-1:0] ijd,
    output logic [WIDTH-1:0] data_out,
    output logic             active,
    output logic             switching
);

    localparam int CW = cnt_width(SETTLE_CYCLES);
    // Counter preload; the zero-settle build never enters a hold state.
    localparam logic [CW-1:0] CNT_LOAD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam bit NO_SETTLE = (SETTLE_CYCLES == 0);

    mux_state_e    state;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FUNC;
            cnt      <= '0;
            data_out <= '0;
        end else begin
            case (state)
                FUNC: begin
                    if (sel && NO_SETTLE) begin
                        state    <= IJTAG;
                        data_out <= ijd;
                    end else begin
                        data_out <= fin;
                        if (sel) begin
                            state <= TO_IJTAG;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                TO_IJTAG: begin
                    if (!sel) begin
                        state    <= FUNC;
                        data_out <= fin;
                    end else if (cnt == '0) begin
                        state    <= IJTAG;
                        data_out <= ijd;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IJTAG: begin
                    if (!sel && NO_SETTLE) begin
                        state    <= FUNC;
                        data_out <= fin;
                    end else begin
                        data_out <= ijd;
                        if (!sel) begin
                            state <= TO_FUNC;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                TO_FUNC: begin
                    if (sel) begin
                        state    <= IJTAG;
                        data_out <= ijd;
                    end else if (cnt == '0) begin
                        state    <= FUNC;
                        data_out <= fin;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= FUNC;
            endcase
        end
    end

    assign active    = (state == IJTAG);
    assign switching = (state == TO_IJTAG) || (state == TO_FUNC);

endmodule

// File: rtl/firebird7_in_gate1_tessent_data_mux_sync.sv
// firebird7_in_gate1_tessent_data_mux_sync: multi-channel glitch-free functional/IJTAG data mux for gate1.
//   ijtag_tck          : clock, all state on rising edge
//   ijtag_reset        : asynchronous active-low reset
//   ijtag_select       : per-channel source request (1 = IJTAG)
//   functional_data_in : channel c in bits [c*WIDTH +: WIDTH]
//   ijtag_data_in      : same packing
//   data_out           : registered muxed data, same packing
//   ijtag_active       : per-channel IJTAG-driving flag
//   switching          : per-channel settle flag
// Optional readback (macro FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CAPTURE_EN):
//   ijtag_capture_en   : snapshot the currently driven data_out
//   capture_data       : last snapshot, same packing
module firebird7_in_gate1_tessent_data_mux_sync #(
    parameter int WIDTH         = 3,
    parameter int NUM_CH        = 1,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                    ijtag_tck,
    input  logic                    ijtag_reset,
    input  logic [NUM_CH-1:0]       ijtag_select,
    input  logic [NUM_CH*WIDTH-1:0] functional_data_in,
    input  logic [NUM_CH*WIDTH-1:0] ijtag_data_in,
    output logic [NUM_CH*WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]       ijtag_active,
`ifdef FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CAPTURE_EN
    output logic [NUM_CH-1:0]       switching,
    input  logic                    ijtag_capture_en,
    output logic [NUM_CH*WIDTH-1:0] capture_data
`else
    output logic [NUM_CH-1:0]       switching
`endif
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        firebird7_in_gate1_tessent_data_mux_ch #(
            .WIDTH         (WIDTH),
            .SETTLE_CYCLES (SETTLE_CYCLES)
        ) u_ch (
            .clk       (ijtag_tck),
            .rst_n     (ijtag_reset),
            .sel       (ijtag_select[c]),
            .fin       (functional_data_in[c*WIDTH +: WIDTH]),
            .ijd       (ijtag_data_in[c*WIDTH +: WIDTH]),
            .data_out  (data_out[c*WIDTH +: WIDTH]),
            .active    (ijtag_active[c]),
            .switching (switching[c])
        );
    end

`ifdef FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CAPTURE_EN
    // Snapshot is of the word already driven, not the one being loaded this edge.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) capture_data <= '0;
        else if (ijtag_capture_en) capture_data <= data_out;
    end
`endif

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_sync.sv
// tb_firebird7_in_gate1_tessent_data_mux_sync: randomized check of two mux builds (settle 2 and settle 0) against a streak-count model.
module tb_firebird7_in_gate1_tessent_data_mux_sync;

    localparam int W  = 3;
    localparam int NC = 4;
    localparam int SV [2] = '{2, 0};

    logic          tck = 1'b0;
    logic          rst_n = 1'b0;
    logic          cap_en = 1'b0;
    logic [NC-1:0]   sel  [2];
    logic [NC*W-1:0] fin  [2];
    logic [NC*W-1:0] ijd  [2];
    logic [NC*W-1:0] dout [2];
    logic [NC-1:0]   act  [2];
    logic [NC-1:0]   sw   [2];
    logic [NC*W-1:0] cap  [2];

    int vectors = 0;
    int miscompares = 0;

    // Model: a channel flips source once the request has differed from the
    // current source on SETTLE+1 consecutive edges; any agreeing edge resets the streak.
    int         streak [2][NC];
    bit         drv    [2][NC];
    logic [W-1:0] m_out [2][NC];
    logic [NC*W-1:0] m_cap [2];

    always #5 tck = ~tck;

    firebird7_in_gate1_tessent_data_mux_sync #(.WIDTH(W), .NUM_CH(NC), .SETTLE_CYCLES(2)) u_a (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst_n),
        .ijtag_select       (sel[0]),
        .functional_data_in (fin[0]),
        .ijtag_data_in      (ijd[0]),
        .data_out           (dout[0]),
        .ijtag_active       (act[0]),
`ifdef FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CAPTURE_EN
        .switching          (sw[0]),
        .ijtag_capture_en   (cap_en),
        .capture_data       (cap[0])
`else
        .switching          (sw[0])
`endif
    );

    firebird7_in_gate1_tessent_data_mux_sync #(.WIDTH(W), .NUM_CH(NC), .SETTLE_CYCLES(0)) u_b (
        .ijtag_tck          (tck),
        .ijtag_reset        (rst_n),
        .ijtag_select       (sel[1]),
        .functional_data_in (fin[1]),
        .ijtag_data_in      (ijd[1]),
        .data_out           (dout[1]),
        .ijtag_active       (act[1]),
`ifdef FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CAPTURE_EN
        .switching          (sw[1]),
        .ijtag_capture_en   (cap_en),
        .capture_data       (cap[1])
`else
        .switching          (sw[1])
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [W-1:0] src(input int k, input int c, input bit ij);
        return ij ? ijd[k][c*W +: W] : fin[k][c*W +: W];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cap[k] = '0;
            for (int c = 0; c < NC; c++) begin
                streak[k][c] = 0;
                drv[k][c]    = 1'b0;
                m_out[k][c]  = '0;
            end
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [NC*W-1:0] packed_out;
            for (int c = 0; c < NC; c++) packed_out[c*W +: W] = m_out[k][c];
            if (cap_en) m_cap[k] = packed_out;
            for (int c = 0; c < NC; c++) begin
                if (sel[k][c] == drv[k][c]) begin
                    streak[k][c] = 0;
                    m_out[k][c]  = src(k, c, drv[k][c]);
                end else begin
                    streak[k][c]++;
                    if (streak[k][c] > SV[k]) begin
                        drv[k][c]    = sel[k][c];
                        streak[k][c] = 0;
                        m_out[k][c]  = src(k, c, drv[k][c]);
                    end else if (streak[k][c] == 1) begin
                        m_out[k][c] = src(k, c, drv[k][c]);
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            logic [NC*W-1:0] e_out;
            logic [NC-1:0]   e_act, e_sw;
            for (int c = 0; c < NC; c++) begin
                e_out[c*W +: W] = m_out[k][c];
                e_act[c] = drv[k][c] && streak[k][c] == 0;
                e_sw[c]  = streak[k][c] != 0;
            end
            chk(k == 0 ? "a_data_out" : "b_data_out", 64'(dout[k]), 64'(e_out));
            chk(k == 0 ? "a_ijtag_active" : "b_ijtag_active", 64'(act[k]), 64'(e_act));
            chk(k == 0 ? "a_switching" : "b_switching", 64'(sw[k]), 64'(e_sw));
`ifdef FIREBIRD7_IN_GATE1_TESSENT_DATA_MUX_CAPTURE_EN
            chk(k == 0 ? "a_capture" : "b_capture", 64'(cap[k]), 64'(m_cap[k]));
`endif
        end
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, then check.
    task automatic run_cycle(input logic [NC-1:0] sa, input logic [NC-1:0] sb, input logic ce);
        sel[0] = sa;
        sel[1] = sb;
        cap_en = ce;
        for (int k = 0; k < 2; k++) begin
            fin[k] = (NC*W)'($urandom);
            ijd[k] = (NC*W)'($urandom);
        end
        @(posedge tck);
        #1;
        model_step();
        check_all();
        @(negedge tck);
    endtask

    // Called at a falling edge: reset must clear outputs immediately and across an edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge tck);
        #1;
        check_all();
        @(negedge tck);
        rst_n = 1'b1;
    endtask

    function automatic logic [NC-1:0] flip_mask();
        logic [NC-1:0] m;
        for (int c = 0; c < NC; c++) m[c] = ($urandom_range(0, 4) == 0);
        return m;
    endfunction

    initial begin
        sel[0] = '0;
        sel[1] = '0;
        fin[0] = '0;
        fin[1] = '0;
        ijd[0] = '0;
        ijd[1] = '0;
        model_reset();
        @(negedge tck);
        do_reset();
        repeat (3) run_cycle('0, '0, 1'b0);
        run_cycle(4'b0001, 4'b0101, 1'b0);
        run_cycle(4'b0000, 4'b0101, 1'b1);
        run_cycle(4'b0000, 4'b0000, 1'b0);
        run_cycle(4'b0011, 4'b0101, 1'b0);
        do_reset();
        repeat (3) run_cycle('0, '0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            run_cycle(sel[0] ^ flip_mask(), sel[1] ^ flip_mask(), 1'($urandom_range(0, 3) == 0));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
